// File: rtl/bitserial_pkg.sv
// Shared defaults and helpers for the bit-serial datapath sequencer.
package bitserial_pkg;

  localparam int BS_W         = 8;
  localparam int BS_DEPTH     = 3;
  localparam int BS_OUT_PHASE = 4;

  typedef logic [$clog2(BS_W)-1:0] bitidx_t;

  function automatic logic [BS_W-1:0] onehot(
    input bitidx_t idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/phase_ring.sv
// Enable-gated one-hot bit-phase ring; parks on bit 0 after reset.
module phase_ring
  import bitserial_pkg::*;
#(
  parameter int W = BS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ctl,
  output logic         at_last
);

  logic [W-1:0] r_ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl <= W'(1);
    end else if (en) begin
      r_ctl <= {r_ctl[W-2:0], r_ctl[W-1]};
    end
  end

  assign ctl     = r_ctl;
  assign at_last = r_ctl[W-1];

endmodule

// File: rtl/bitserial_seq.sv
// Frame sequencer: bit-phase ring, datapath enable, frame tokens
// and result handshake for the bit-serial adder tree.
module bitserial_seq
  import bitserial_pkg::*;
#(
  parameter int W         = BS_W,
  parameter int DEPTH     = BS_DEPTH,
  parameter int OUT_PHASE = BS_OUT_PHASE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         en,
  output logic [W-1:0] ctl,
  output logic         busy
);

  if (OUT_PHASE < 1 || OUT_PHASE > W-1 || DEPTH < 1)
  begin : g_bad_param
    $error("bitserial_seq: illegal OUT_PHASE/DEPTH");
  end

  logic [W-1:0]   w_ctl;
  logic           w_at_last;
  logic           w_stall;
  logic           w_accept;
  logic           w_set_ov;
  logic [DEPTH:0] r_tok;
  logic           r_ov;

  assign w_stall  = r_ov & ~out_ready;
  assign en       = ~w_stall &
                    (in_valid | (|r_tok) | ~w_ctl[0]);
  assign in_ready = w_ctl[0] & ~w_stall;
  assign w_accept = in_valid & in_ready;

  phase_ring #(.W(W)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ctl     (w_ctl),
    .at_last (w_at_last)
  );

  // Tokens mark frames holding real data; they shift at frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tok <= '0;
    end else if (en & w_ctl[0]) begin
      r_tok[0] <= w_accept;
    end else if (en & w_at_last) begin
      r_tok <= {r_tok[DEPTH-1:0], 1'b0};
    end
  end

  assign w_set_ov = en & w_ctl[OUT_PHASE-1] & r_tok[DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov <= 1'b0;
    end else if (w_set_ov) begin
      r_ov <= 1'b1;
    end else if (r_ov & out_ready) begin
      r_ov <= 1'b0;
    end
  end

  assign ctl       = w_ctl;
  assign out_valid = r_ov;
  assign busy      = (|r_tok) | r_ov;

endmodule

// File: doc/bitserial_seq.md
Name: bitserial_seq

Overview:
Frame sequencer for the bit-serial adder-tree datapath (parallel-to-serial load, serial add layers, serial-to-parallel capture).
- Generates the one-hot bit-phase ring and a global datapath enable.
- Accepts operand word-sets over a valid/ready handshake.
- Tracks which frames carry real data through the pipeline.
- Presents results with valid/ready, stalling the whole datapath under backpressure.

Parameters:
W, 8, word width in bits = cycles per frame; ring width.
DEPTH, 3, frames from operand-load frame to result frame.
OUT_PHASE, 4, bit phase at which the captured result is valid; legal range 1..W-1.

Ports:
clk  in  1  single clock, all state on posedge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand set (a,b,c,d) presented to datapath.
in_ready  out  1  operand set accepted this cycle when in_valid & in_ready.
out_valid  out  1  result word valid at datapath output.
out_ready  in  1  consumer takes result.
en  out  1  datapath enable; every datapath register and the ring advance only when en=1.
ctl  out  W  one-hot bit phase; ctl[k]=1 when bitcnt==k.
busy  out  1  any token in flight or out_valid held.

Behaviour:
- State: bitcnt (0..W-1, exposed as one-hot ctl), token vector tok[DEPTH:0], out_valid flag.
- Reset (rst=1 at an edge, from any state): bitcnt=0 (ctl=1), tok=0, out_valid=0. Resulting outputs: en=0, in_ready=1, busy=0. Reset mid-frame discards all in-flight words; no later out_valid.
- stall = out_valid & ~out_ready.
- en = ~stall & (in_valid | |tok | bitcnt!=0).
  - Idle: ring parks at bitcnt=0.
  - A partially run frame always completes.
- in_ready = (bitcnt==0) & ~stall.
  - Combinational from out_ready; consumers must not make out_ready depend on in_ready.
  - in_valid mid-frame waits until bitcnt returns to 0.
- accept = in_valid & in_ready. Datapath loads operands on en & ctl[0].
- Ring: when en, bitcnt <= (bitcnt==W-1) ? 0 : bitcnt+1. When en=0, ctl is frozen.
- Tokens, only when en:
  - Edge leaving bitcnt=0: tok[0] <= accept.
  - Edge at bitcnt=W-1 (frame boundary): tok <= {tok[DEPTH-1:0],0}; tok[DEPTH] drops out.
  - These two edges never coincide (W>=2).
- out_valid:
  - Set on the en edge entering bitcnt==OUT_PHASE while tok[DEPTH]=1.
  - Cleared on the edge where out_valid & out_ready.
  - Set and clear cannot coincide.
- Latency without stall: accept at cycle T, out_valid first high at T + DEPTH*W + OUT_PHASE (default 28).
- Stall: each stalled cycle adds exactly one cycle of latency to every word in flight.
- Throughput: one word-set per W cycles, fully pipelined.
- busy = |tok | out_valid.
- Elaboration error if OUT_PHASE outside 1..W-1 or DEPTH<1.

Decomposition:
- Package bitserial_pkg holds:
  - default W/DEPTH/OUT_PHASE localparams;
  - bit-index type logic [$clog2(W)-1:0];
  - function onehot(idx) returning logic [W-1:0].
- Sub-module phase_ring: enable-gated one-hot ring counter (clk, rst, en, ctl, at_last). Reused by the serial-to-parallel converter.

Test Plan:
- Reset: hold rst 3 cycles mid-traffic -> ctl=8'h01, en=0, in_ready=1, out_valid=0, busy=0.
- Single word accepted at cycle 0, out_ready=1 -> en high through cycle 31; out_valid only at cycle 28 with ctl=8'h10; en=0, busy=0 from cycle 32.
- in_valid held, 4 sets -> accepts at cycles 0, 8, 16, 24 (in_ready only when ctl=8'h01); out_valid at 28, 36, 44, 52.
- Backpressure: out_ready=0 cycles 28-32 -> en=0, ctl frozen at 8'h10, in_ready=0, out_valid held; next out_valid at 41 (36+5).
- in_valid raised at bitcnt=3 of a running frame -> in_ready=0 until ctl=8'h01, accept there; latency 28 measured from the accept.
- rst pulsed at cycle 15 after one accept -> next cycle all reset values; no out_valid over the following 40 cycles.
